// File: rtl/cpu_fetch_squash_pkg.sv
// cpu_fetch_squash_pkg: shared opcode, width and squash-length helpers for the fetch stage
package cpu_fetch_squash_pkg;
    localparam int IR_WIDTH = 12;
    localparam logic [IR_WIDTH-1:0] NOP = 12'h000;
    localparam int DEF_MAX_SQUASH = 3;
    function automatic int clamp_len(input int len, input int max_len);
        return (len == 0) ? 1 : ((len > max_len) ? max_len : len);
    endfunction
endpackage

// File: rtl/cpu_squash_counter.sv
// cpu_squash_counter: loadable remaining-bubble down-counter with hold, clamp-on-load and zero flag
module cpu_squash_counter
    import cpu_fetch_squash_pkg::*;
#(
    parameter int MAX_SQUASH    = DEF_MAX_SQUASH,
    parameter int CW            = 2,
    parameter int RESET_BUBBLES = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [CW-1:0] load_len,
    input  logic          hold,
    output logic [CW-1:0] rem,
    output logic          busy
);
    logic [CW-1:0] rem_n;
    // the load itself is one bubble, so only eff-1 remain afterwards
    always_comb begin
        rem_n = load ? CW'(clamp_len(int'(load_len), MAX_SQUASH) - 1)
              : hold ? rem
              : (rem != '0) ? rem - 1'b1 : rem;
    end
    always_ff @(posedge clk) begin
        if (!resetn) rem <= CW'(RESET_BUBBLES);
        else         rem <= rem_n;
    end
    assign busy = (rem != '0);
endmodule

// File: rtl/cpu_fetch_squash.sv
// cpu_fetch_squash: registered IR stage injecting NOP bubbles after squash, stall-aware, with bubble counter
module cpu_fetch_squash
    import cpu_fetch_squash_pkg::*;
#(
    parameter int               WIDTH         = IR_WIDTH,
    parameter logic [WIDTH-1:0] NOP_WORD      = WIDTH'(NOP),
    parameter int               MAX_SQUASH    = DEF_MAX_SQUASH,
    parameter int               CW            = 2,
    parameter int               RESET_BUBBLES = 1,
    parameter int               PERF_W        = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              squash_req,
    input  logic [CW-1:0]     squash_len,
    input  logic              perf_clr,
    input  logic [WIDTH-1:0]  program_bus_in,
    output logic [WIDTH-1:0]  program_bus_out,
    output logic              nop_active,
    output logic              busy,
    output logic [PERF_W-1:0] bubble_count
);
    logic [CW-1:0] rem;
    logic          inject;
    logic          advance;
    cpu_squash_counter #(
        .MAX_SQUASH   (MAX_SQUASH),
        .CW           (CW),
        .RESET_BUBBLES(RESET_BUBBLES)
    ) u_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .load    (squash_req),
        .load_len(squash_len),
        .hold    (stall),
        .rem     (rem),
        .busy    (busy)
    );
    // squash beats stall; otherwise stall freezes both the IR and the bubble sequence
    assign inject  = squash_req | (!stall & (rem != '0));
    assign advance = squash_req | !stall;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            program_bus_out <= NOP_WORD;
            nop_active      <= 1'b1;
            bubble_count    <= '0;
        end else begin
            if (advance) begin
                program_bus_out <= inject ? NOP_WORD : program_bus_in;
                nop_active      <= inject;
            end
            bubble_count <= perf_clr ? '0
                          : (inject && bubble_count != '1) ? bubble_count + 1'b1
                          : bubble_count;
        end
    end
endmodule

// File: tb/tb_cpu_fetch_squash.sv
// tb_cpu_fetch_squash: directed scoreboard bench for a default instance and a MAX_SQUASH=2/PERF_W=4 instance
module tb_cpu_fetch_squash;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        squash_req = 1'b0;
    logic [1:0]  squash_len = 2'd0;
    logic        perf_clr = 1'b0;
    logic [11:0] program_bus_in = 12'h000;
    logic [11:0] out_a, out_b;
    logic        nop_a, nop_b, busy_a, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] oa;
        logic        na;
        logic        ba;
        logic [11:0] ob;
        logic        nb;
        logic        bb;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_fetch_squash dut_a (
        .clk(clk), .resetn(resetn), .stall(stall), .squash_req(squash_req),
        .squash_len(squash_len), .perf_clr(perf_clr), .program_bus_in(program_bus_in),
        .program_bus_out(out_a), .nop_active(nop_a), .busy(busy_a), .bubble_count(cnt_a)
    );

    cpu_fetch_squash #(.MAX_SQUASH(2), .PERF_W(4)) dut_b (
        .clk(clk), .resetn(resetn), .stall(stall), .squash_req(squash_req),
        .squash_len(squash_len), .perf_clr(perf_clr), .program_bus_in(program_bus_in),
        .program_bus_out(out_b), .nop_active(nop_b), .busy(busy_b), .bubble_count(cnt_b)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit st, input bit sq, input logic [1:0] len,
                        input logic [11:0] pin,
                        input logic [11:0] oa, input bit na, input bit ba,
                        input logic [11:0] ob, input bit nb, input bit bb);
        exp_t e;
        resetn = rn;
        stall = st;
        squash_req = sq;
        squash_len = len;
        program_bus_in = pin;
        e.oa = oa; e.na = na; e.ba = ba;
        e.ob = ob; e.nb = nb; e.bb = bb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic counts(input logic [15:0] ea, input logic [3:0] eb);
        chk("bubble_count_a", cnt_a, ea);
        chk("bubble_count_b", 16'(cnt_b), 16'(eb));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_a", 16'(out_a), 16'(e.oa));
                chk("nop_a", 16'(nop_a), 16'(e.na));
                chk("busy_a", 16'(busy_a), 16'(e.ba));
                chk("out_b", 16'(out_b), 16'(e.ob));
                chk("nop_b", 16'(nop_b), 16'(e.nb));
                chk("busy_b", 16'(busy_b), 16'(e.bb));
            end
        end
    end

    initial begin : stim
        // reset and the single reset bubble
        step(0,0,0,2'd0,12'hA05, 12'h000,1,1, 12'h000,1,1);
        counts(16'd0, 4'd0);
        step(1,0,0,2'd0,12'hA05, 12'h000,1,0, 12'h000,1,0);
        step(1,0,0,2'd0,12'hA05, 12'hA05,0,0, 12'hA05,0,0);
        counts(16'd1, 4'd1);
        // squash len 2
        step(1,0,1,2'd2,12'h111, 12'h000,1,1, 12'h000,1,1);
        step(1,0,0,2'd0,12'h222, 12'h000,1,0, 12'h000,1,0);
        step(1,0,0,2'd0,12'h333, 12'h333,0,0, 12'h333,0,0);
        counts(16'd3, 4'd3);
        // len 3: three bubbles on A, clamped to two on B
        step(1,0,1,2'd3,12'h444, 12'h000,1,1, 12'h000,1,1);
        step(1,0,0,2'd0,12'h555, 12'h000,1,1, 12'h000,1,0);
        step(1,0,0,2'd0,12'h666, 12'h000,1,0, 12'h666,0,0);
        step(1,0,0,2'd0,12'h777, 12'h777,0,0, 12'h777,0,0);
        counts(16'd6, 4'd5);
        // len 0 behaves as 1
        step(1,0,1,2'd0,12'h888, 12'h000,1,0, 12'h000,1,0);
        step(1,0,0,2'd0,12'h999, 12'h999,0,0, 12'h999,0,0);
        counts(16'd7, 4'd6);
        // stall for two cycles mid-sequence
        step(1,0,1,2'd3,12'h100, 12'h000,1,1, 12'h000,1,1);
        step(1,1,0,2'd0,12'h1AA, 12'h000,1,1, 12'h000,1,1);
        step(1,1,0,2'd0,12'h1BB, 12'h000,1,1, 12'h000,1,1);
        counts(16'd8, 4'd7);
        step(1,0,0,2'd0,12'h200, 12'h000,1,1, 12'h000,1,0);
        step(1,0,0,2'd0,12'h300, 12'h000,1,0, 12'h300,0,0);
        step(1,0,0,2'd0,12'h400, 12'h400,0,0, 12'h400,0,0);
        counts(16'd10, 4'd8);
        // stall while idle holds the fetched word
        step(1,1,0,2'd0,12'h500, 12'h400,0,0, 12'h400,0,0);
        // re-squash reloads rather than accumulates
        step(1,0,1,2'd3,12'h600, 12'h000,1,1, 12'h000,1,1);
        step(1,0,1,2'd1,12'h700, 12'h000,1,0, 12'h000,1,0);
        step(1,0,0,2'd0,12'h800, 12'h800,0,0, 12'h800,0,0);
        counts(16'd12, 4'd10);
        // squash overrides stall
        step(1,1,1,2'd2,12'h900, 12'h000,1,1, 12'h000,1,1);
        step(1,0,0,2'd0,12'hA00, 12'h000,1,0, 12'h000,1,0);
        step(1,0,0,2'd0,12'hB00, 12'hB00,0,0, 12'hB00,0,0);
        counts(16'd14, 4'd12);
        // a fetched word equal to the NOP opcode is not a bubble
        step(1,0,0,2'd0,12'h000, 12'h000,0,0, 12'h000,0,0);
        // twenty bubbles: B saturates at 15
        for (int i = 0; i < 20; i++)
            step(1,0,1,2'd1,12'h0F0, 12'h000,1,0, 12'h000,1,0);
        counts(16'd34, 4'd15);
        // clear wins over a simultaneous bubble
        perf_clr = 1'b1;
        step(1,0,1,2'd1,12'h0F1, 12'h000,1,0, 12'h000,1,0);
        perf_clr = 1'b0;
        counts(16'd0, 4'd0);
        step(1,0,0,2'd0,12'h123, 12'h123,0,0, 12'h123,0,0);
        counts(16'd0, 4'd0);
        // reset mid-sequence reloads the reset bubble count
        step(1,0,1,2'd3,12'h001, 12'h000,1,1, 12'h000,1,1);
        counts(16'd1, 4'd1);
        step(0,0,0,2'd0,12'h002, 12'h000,1,1, 12'h000,1,1);
        counts(16'd0, 4'd0);
        step(1,0,0,2'd0,12'h003, 12'h000,1,0, 12'h000,1,0);
        step(1,0,0,2'd0,12'h004, 12'h004,0,0, 12'h004,0,0);
        counts(16'd1, 4'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_fetch_squash.md
Name: cpu_fetch_squash

Overview:
- Registered instruction-register stage between program memory and the decoder.
- Replaces fetched words with NOP for a programmable number of cycles after a squash request (taken GOTO/CALL/RETLW, skip-taken BTFSx/xFSZ), and holds the word under stall.
- Counts inserted bubbles for performance debug.
- Successor to the combinational NOP mux: multi-cycle, width/depth parametrised, stall-aware, with reset bubbles.

Parameters:
- WIDTH, 12, instruction word width.
- NOP_WORD, 12'h000, word injected as a bubble; bound from `NOP in definition.vh.
- MAX_SQUASH, 3, maximum bubbles per squash request; must be ≥1.
- CW, 2, counter width; must satisfy 2^CW > MAX_SQUASH.
- RESET_BUBBLES, 1, bubbles issued after reset release; range 0..MAX_SQUASH.
- PERF_W, 16, bubble performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- stall  in  1  hold IR contents and bubble counter this cycle.
- squash_req  in  1  start a new bubble sequence.
- squash_len  in  CW  bubbles requested with squash_req.
- perf_clr  in  1  synchronous clear of bubble_count.
- program_bus_in  in  WIDTH  word from program memory.
- program_bus_out  out  WIDTH  registered instruction to decoder.
- nop_active  out  1  program_bus_out is an injected bubble, not a fetched word.
- busy  out  1  remaining-bubble counter is nonzero.
- bubble_count  out  PERF_W  saturating count of injected bubbles.

Behaviour:
- All state updates on the rising clk edge. One clock, no combinational path from inputs to program_bus_out. Latency is 1 cycle.
- Reset values (resetn=0 at the edge):
  - program_bus_out=NOP_WORD, nop_active=1, bubble_count=0.
  - rem=RESET_BUBBLES; busy=(RESET_BUBBLES!=0) from the same edge.
  - Reset mid-sequence discards any pending bubbles and reloads RESET_BUBBLES.
- Priority per edge when resetn=1: squash_req > stall > rem!=0 > normal fetch.
  - squash_req=1:
    - eff = clamp(squash_len), with 0 treated as 1 and values above MAX_SQUASH treated as MAX_SQUASH.
    - out←NOP_WORD, nop_active←1, rem←eff-1.
    - Reload, not accumulate, when already busy.
    - Squash overrides stall.
  - stall=1: out, nop_active and rem all hold. No bubble is counted.
  - rem!=0: out←NOP_WORD, nop_active←1, rem←rem-1.
  - Otherwise: out←program_bus_in, nop_active←0, rem holds at 0.
- busy = (rem!=0), combinational from the register.
- Bubble counter:
  - bubble_count increments by 1 on every edge that loads an injected NOP, whether from squash or from rem.
  - It saturates at 2^PERF_W-1.
  - perf_clr has priority over increment; the result is 0 that cycle.
  - The reset-bubble load does not count.
- A fetched word equal to NOP_WORD passes through with nop_active=0.
- Total bubbles for one uninterrupted squash = eff cycles, stall cycles excluded.

Decomposition:
- definition.vh (shared include):
  - `NOP opcode.
  - Default `MAX_SQUASH.
  - `IR_WIDTH=12.
- Sub-module cpu_squash_counter:
  - Loadable down-counter with hold, load-priority, clamp-on-load and zero flag.
  - Instantiated once, outputs rem/busy.
- Output mux and perf counter stay in the top module.

Test Plan:
- Reset release, RESET_BUBBLES=1, program_bus_in=12'hA05 constant:
  - First edge after resetn=1 → out=000, nop_active=1.
  - Next edge → out=A05, nop_active=0.
  - bubble_count=1.
- squash_req with squash_len=2, inputs 12'h111,12'h222,12'h333 on consecutive cycles → out=000,000,333; busy high for exactly 1 cycle; bubble_count+=2.
- Clamp/zero:
  - squash_len=3 with MAX_SQUASH=2 → exactly 2 bubbles.
  - squash_len=0 → exactly 1 bubble.
- Stall during sequence: squash_len=3, stall asserted on cycle 2 for 2 cycles → out stays 000, rem frozen, 3 total bubbles, bubble_count+=3 (not 5).
- Re-squash while busy: squash_len=3, second squash_req with len=1 one cycle later → total 2 bubbles (reload, not sum). Squash together with stall → out=000 regardless.
- Saturation and clear, PERF_W=4:
  - Drive 20 bubbles → bubble_count=15.
  - perf_clr together with a bubble → 0.
  - Mid-sequence resetn=0 → out=000, counter restarts at RESET_BUBBLES.
